// File: rtl/fetch_queue_pkg.sv
// ============================================================================
// Module  : fetch_queue_pkg
// Brief   : Shared fetch-path configuration constants and entry type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_queue_pkg;

  localparam int FETCH_XLEN  = 32;
  localparam int FETCH_TAG_W = 1;
  localparam int FETCH_DEPTH = 4;
  localparam int ROM_LATENCY = 1;

  typedef struct packed {
    logic [FETCH_XLEN-1:0]  instr;
    logic [FETCH_XLEN-1:0]  addr;
    logic [FETCH_TAG_W-1:0] tag;
  } fetch_entry_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module  : fetch_queue_if
// Brief   : Request, ROM and decoder-side signals of the fetch queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = FETCH_XLEN,
  parameter int TAG_W = FETCH_TAG_W,
  parameter int DEPTH = FETCH_DEPTH
);

  localparam int CW = cnt_width(DEPTH);

  logic             req_valid;
  logic [XLEN-1:0]  req_addr;
  logic [TAG_W-1:0] req_tag;
  logic             req_ready;

  logic             rom_rden;
  logic [XLEN-1:0]  rom_addr;
  logic [XLEN-1:0]  rom_instr;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_instr;
  logic [XLEN-1:0]  out_addr;
  logic [TAG_W-1:0] out_tag;

  logic [CW-1:0]    occupancy;

  // Environment side: fetch stage, ROM and decoder.
  modport master (
    output req_valid, req_addr, req_tag, rom_instr, out_ready,
    input  req_ready, rom_rden, rom_addr, out_valid, out_instr, out_addr,
           out_tag, occupancy
  );

  modport slave (
    input  req_valid, req_addr, req_tag, rom_instr, out_ready,
    output req_ready, rom_rden, rom_addr, out_valid, out_instr, out_addr,
           out_tag, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue_latency_line.sv
// ============================================================================
// Module  : fetch_latency_line
// Brief   : Valid-tagged shift line matching the ROM read latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_latency_line #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clk_en,
  input  wire logic             kill,
  input  wire logic             in_valid,
  input  wire logic [WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data
);

  logic             r_valid [LAT];
  logic [WIDTH-1:0] r_data  [LAT];

  for (genvar i = 0; i < LAT; i++) begin : g_stage
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid[0] <= 1'b0;
        end else if (clk_en) begin
          r_valid[0] <= in_valid & ~kill;
        end
      end

      always_ff @(posedge clk) begin
        if (clk_en) begin
          r_data[0] <= in_data;
        end
      end
    end else begin : g_body
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid[i] <= 1'b0;
        end else if (clk_en) begin
          r_valid[i] <= r_valid[i-1] & ~kill;
        end
      end

      always_ff @(posedge clk) begin
        if (clk_en) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_data  = r_data[LAT-1];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module  : fetch_queue
// Brief   : Fetch decoupling buffer pairing ROM data with its address/tag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN    = FETCH_XLEN,
  parameter int DEPTH   = FETCH_DEPTH,
  parameter int ROM_LAT = ROM_LATENCY,
  parameter int TAG_W   = FETCH_TAG_W
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     clk_en,
  input  wire logic     flush,
  fetch_queue_if.slave  bus
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = XLEN + TAG_W;
  localparam logic [CW:0] c_depth = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  addr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  entry_t        r_mem [DEPTH];

  logic          w_rden;
  logic [CW:0]   w_credit_used;
  logic          w_ret_valid;
  logic [LW-1:0] w_ret_data;
  logic          w_wr;
  logic          w_rd;
  logic          w_out_valid;
  entry_t        w_head;
  entry_t        w_wr_entry;

  // Credits cover both queued and in-flight words so a return always has room.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign bus.req_ready = ~flush & (w_credit_used < c_depth);
  assign w_rden        = bus.req_valid & bus.req_ready;
  assign bus.rom_rden  = w_rden;
  assign bus.rom_addr  = bus.req_addr;

  fetch_latency_line #(
    .WIDTH (LW),
    .LAT   (ROM_LAT)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .kill      (flush),
    .in_valid  (w_rden),
    .in_data   ({bus.req_addr, bus.req_tag}),
    .out_valid (w_ret_valid),
    .out_data  (w_ret_data)
  );

  assign w_out_valid = (r_count != '0);
  assign w_wr        = w_ret_valid & ~flush;
  assign w_rd        = w_out_valid & bus.out_ready & ~flush;

  assign w_wr_entry.instr = bus.rom_instr;
  assign w_wr_entry.addr  = w_ret_data[LW-1:TAG_W];
  assign w_wr_entry.tag   = w_ret_data[TAG_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_inflight <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (clk_en) begin
      if (flush) begin
        r_count    <= '0;
        r_inflight <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count    <= r_count + CW'(w_wr) - CW'(w_rd);
        r_inflight <= r_inflight + CW'(w_rden) - CW'(w_ret_valid);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clk_en && w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && clk_en) begin
      assert (!(w_wr && !w_rd && (r_count == CW'(DEPTH))))
        else $error("fetch_queue: write into full FIFO");
    end
  end
`endif

  // Empty queue presents zeros so the outputs match their reset values.
  assign w_head        = r_mem[r_rd_ptr];
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_head.instr : '0;
  assign bus.out_addr  = w_out_valid ? w_head.addr  : '0;
  assign bus.out_tag   = w_out_valid ? w_head.tag   : '0;
  assign bus.occupancy = r_count + r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Directed self-checking bench for fetch_queue (ROM_LAT 1 and 3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  logic flush_a;
  logic flush_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32), .TAG_W(1), .DEPTH(4)) bus_a ();
  fetch_queue_if #(.XLEN(32), .TAG_W(1), .DEPTH(4)) bus_b ();

  fetch_queue #(.XLEN(32), .DEPTH(4), .ROM_LAT(1), .TAG_W(1)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush_a), .bus(bus_a)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .ROM_LAT(3), .TAG_W(1)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush_b), .bus(bus_b)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0F0F;
  endfunction

  // ROM models, gated by the same clock enable as the DUT.
  logic [31:0] rom_a_q;
  logic [31:0] rom_b_q [3];
  always @(posedge clk) begin
    if (clk_en) begin
      rom_a_q    <= rom_f(bus_a.rom_addr);
      rom_b_q[0] <= rom_f(bus_b.rom_addr);
      rom_b_q[1] <= rom_b_q[0];
      rom_b_q[2] <= rom_b_q[1];
    end
  end
  assign bus_a.rom_instr = rom_a_q;
  assign bus_b.rom_instr = rom_b_q[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] a, input logic t);
    bus_a.req_valid = v;
    bus_a.req_addr  = a;
    bus_a.req_tag   = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int issued;
    int recv;
    logic [31:0] addr;

    rst = 1'b1; clk_en = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0);
    bus_a.out_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_tag = '0;
    bus_b.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_occupancy", 32'(bus_a.occupancy), 32'd0);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd1);
    chk("rst_out_addr",  bus_a.out_addr, 32'd0);
    chk("rst_rom_rden",  32'(bus_a.rom_rden), 32'd0);

    // Back-to-back fetches, decoder always ready.
    bus_a.out_ready = 1'b1;
    drive_a(1'b1, 32'h00, 1'b0); settle();
    chk("t1_rom_rden", 32'(bus_a.rom_rden), 32'd1);
    chk("t1_rom_addr", bus_a.rom_addr, 32'h00);
    tick();
    drive_a(1'b1, 32'h04, 1'b1); tick();
    drive_a(1'b1, 32'h08, 1'b0); settle();
    chk("t1_c2_valid", 32'(bus_a.out_valid), 32'd1);
    chk("t1_c2_addr",  bus_a.out_addr, 32'h00);
    chk("t1_c2_instr", bus_a.out_instr, rom_f(32'h00));
    chk("t1_c2_occ",   32'(bus_a.occupancy), 32'd2);
    tick();
    drive_a(1'b0, 32'h0, 1'b0); settle();
    chk("t1_c3_addr", bus_a.out_addr, 32'h04);
    chk("t1_c3_tag",  32'(bus_a.out_tag), 32'd1);
    tick(); settle();
    chk("t1_c4_addr",  bus_a.out_addr, 32'h08);
    chk("t1_c4_instr", bus_a.out_instr, rom_f(32'h08));
    tick(); settle();
    chk("t1_c5_empty", 32'(bus_a.out_valid), 32'd0);
    chk("t1_c5_occ",   32'(bus_a.occupancy), 32'd0);

    // Decoder stalled: credits allow exactly DEPTH fetches.
    bus_a.out_ready = 1'b0;
    acc = 0; addr = 32'h10;
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, addr, 1'b0); settle();
      if (bus_a.req_ready) begin acc++; addr += 32'd4; end
      tick();
    end
    settle();
    chk("t2_accepted", 32'(acc), 32'd4);
    chk("t2_occ_full", 32'(bus_a.occupancy), 32'd4);
    chk("t2_not_ready", 32'(bus_a.req_ready), 32'd0);
    drive_a(1'b0, 32'h0, 1'b0);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t2_drain_valid", 32'(bus_a.out_valid), 32'd1);
      chk("t2_drain_addr",  bus_a.out_addr, 32'h10 + 32'(4 * i));
      chk("t2_drain_instr", bus_a.out_instr, rom_f(32'h10 + 32'(4 * i)));
      tick();
    end
    settle();
    chk("t2_drained", 32'(bus_a.out_valid), 32'd0);

    // Flush with two queued and one in flight.
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 32'h20, 1'b0); tick();
    drive_a(1'b1, 32'h24, 1'b0); tick();
    drive_a(1'b1, 32'h28, 1'b0); tick();
    flush_a = 1'b1;
    drive_a(1'b1, 32'h100, 1'b1); settle();
    chk("t3_pre_occ",      32'(bus_a.occupancy), 32'd3);
    chk("t3_flush_ready",  32'(bus_a.req_ready), 32'd0);
    chk("t3_flush_rden",   32'(bus_a.rom_rden), 32'd0);
    tick();
    flush_a = 1'b0; settle();
    chk("t3_post_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t3_post_occ",   32'(bus_a.occupancy), 32'd0);
    chk("t3_post_ready", 32'(bus_a.req_ready), 32'd1);
    tick();
    drive_a(1'b0, 32'h0, 1'b0);
    bus_a.out_ready = 1'b1; settle();
    chk("t3_c5_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t3_c5_occ",   32'(bus_a.occupancy), 32'd1);
    tick(); settle();
    chk("t3_new_valid", 32'(bus_a.out_valid), 32'd1);
    chk("t3_new_addr",  bus_a.out_addr, 32'h100);
    chk("t3_new_instr", bus_a.out_instr, rom_f(32'h100));
    chk("t3_new_tag",   32'(bus_a.out_tag), 32'd1);
    tick(); settle();
    chk("t3_end_valid", 32'(bus_a.out_valid), 32'd0);

    // One disabled cycle mid-flight delays the output by one cycle.
    drive_a(1'b1, 32'h200, 1'b1); tick();
    drive_a(1'b0, 32'h0, 1'b0);
    clk_en = 1'b0; settle();
    chk("t4_off_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t4_off_occ",   32'(bus_a.occupancy), 32'd1);
    tick();
    clk_en = 1'b1; settle();
    chk("t4_on_valid", 32'(bus_a.out_valid), 32'd0);
    tick(); settle();
    chk("t4_out_valid", 32'(bus_a.out_valid), 32'd1);
    chk("t4_out_addr",  bus_a.out_addr, 32'h200);
    chk("t4_out_instr", bus_a.out_instr, rom_f(32'h200));
    chk("t4_out_tag",   32'(bus_a.out_tag), 32'd1);
    tick(); settle();
    chk("t4_end_valid", 32'(bus_a.out_valid), 32'd0);

    // Reset with a full FIFO while the clock enable is low.
    bus_a.out_ready = 1'b0;
    addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, addr, 1'b1); settle();
      if (bus_a.req_ready) addr += 32'd4;
      tick();
    end
    drive_a(1'b0, 32'h0, 1'b0);
    settle();
    chk("t6_full_occ", 32'(bus_a.occupancy), 32'd4);
    clk_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; clk_en = 1'b1; settle();
    chk("t6_rst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("t6_rst_occ",   32'(bus_a.occupancy), 32'd0);
    chk("t6_rst_addr",  bus_a.out_addr, 32'd0);
    chk("t6_rst_instr", bus_a.out_instr, 32'd0);
    chk("t6_rst_tag",   32'(bus_a.out_tag), 32'd0);
    chk("t6_rst_ready", 32'(bus_a.req_ready), 32'd1);

    // ROM_LAT=3 stream: first word after a 4-cycle fill, order preserved.
    bus_b.out_ready = 1'b1;
    issued = 0; recv = 0;
    for (int c = 0; c < 60 && recv < 12; c++) begin
      bus_b.req_valid = (issued < 12);
      bus_b.req_addr  = 32'h400 + 32'(4 * issued);
      bus_b.req_tag   = 1'(issued);
      settle();
      if (c == 3) chk("b_fill_empty", 32'(bus_b.out_valid), 32'd0);
      if (c == 4) chk("b_first_valid", 32'(bus_b.out_valid), 32'd1);
      if (bus_b.out_valid) begin
        chk("b_addr",  bus_b.out_addr, 32'h400 + 32'(4 * recv));
        chk("b_instr", bus_b.out_instr, rom_f(32'h400 + 32'(4 * recv)));
        chk("b_tag",   32'(bus_b.out_tag), 32'(recv & 1));
        recv++;
      end
      if (bus_b.req_valid && bus_b.req_ready) issued++;
      tick();
    end
    bus_b.req_valid = 1'b0;
    chk("b_recv_count", 32'(recv), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch decoupling buffer between the program-counter/prediction stage and the decoder. It tracks every address issued to the fixed-latency program ROM, carries the matching address and prediction tag alongside, and pairs each returned instruction with its address. Results are queued in a FIFO so decoder stalls never lose fetched words. Flush squashes both queued and in-flight fetches, and credit-based issue control guarantees the FIFO can never overflow.

## Interface
Parameters:
- XLEN, 32, instruction/address width
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- ROM_LAT, 1, ROM read latency in enabled cycles; ≥ 1
- TAG_W, 1, sideband width (bit 0 = predicted-taken)

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  global clock enable; all state holds when low
- flush  in  1  squash queued and in-flight fetches
- req_valid  in  1  upstream presents a fetch address
- req_addr  in  XLEN  fetch address
- req_tag  in  TAG_W  prediction sideband
- req_ready  out  1  fetch accepted this cycle
- rom_rden  out  1  ROM read strobe, = req_valid & req_ready
- rom_addr  out  XLEN  = req_addr
- rom_instr  in  XLEN  ROM data, valid ROM_LAT enabled cycles after rom_rden
- out_valid  out  1  head entry valid
- out_ready  in  1  decoder accepts head
- out_instr / out_addr  out  XLEN  head instruction / address
- out_tag  out  TAG_W  head sideband
- occupancy  out  $clog2(DEPTH)+1  FIFO count plus in-flight count

## Operation
- All state updates only on clock edges with clk_en=1. rst overrides clk_en.
- Issue:
  - req_ready = !flush & (fifo_count + inflight_count < DEPTH).
  - On accept, push {1, req_addr, req_tag} into a ROM_LAT-stage latency line.
- Return: when the line's last stage is valid, write {rom_instr, addr, tag} into the FIFO on that edge.
- Drain:
  - out_* always show the FIFO head.
  - Pop when out_valid & out_ready.
- Simultaneous push and pop: count unchanged. Pop and push are both legal when the FIFO is full.
- Flush:
  - Empty the FIFO.
  - Clear every valid bit in the latency line. ROM data for killed slots is ignored.
  - No request is accepted in the flush cycle.
  - A request accepted on the following cycle is unaffected.
- Flush wins over a same-cycle return and a same-cycle pop. Neither is counted.
- Credit rule makes overflow impossible. Simulation assertion: FIFO write when full → error.
- Pointers wrap modulo DEPTH; count range 0..DEPTH.
- clk_en=0 mid-flight: latency line and FIFO freeze. rom_rden is still derived combinationally, but upstream must hold it (ROM is gated by the same clk_en).

## Timing
- Reset values: req_ready=1 (when !flush), rom_rden=req_valid, out_valid=0, out_instr/out_addr/out_tag=0, occupancy=0, latency line invalid.
- Request accepted at enabled cycle T → rom_instr sampled at T+ROM_LAT → out_valid=1 at T+ROM_LAT+1 if the FIFO was empty.
- Throughput: 1 fetch/cycle sustained when DEPTH ≥ ROM_LAT+1 and out_ready=1.
- out_* registered. No combinational path from rom_instr or out_ready to any output.
- req_ready depends combinationally only on flush and registered counts.
- Reset asserted mid-operation: all of the above reset values apply on the next edge, regardless of clk_en.

## Structure
- core_config_pkg additions:
  - constants FETCH_DEPTH, ROM_LATENCY
  - typedef fetch_entry_t (packed: instr, addr, tag)
- Sub-module fetch_latency_line #(WIDTH, LAT): valid-tagged shift line with clk_en and kill.
- fetch_queue instantiates fetch_latency_line plus an inline circular FIFO with read/write pointers and a count.

## Test plan
- Reset, ROM_LAT=1, DEPTH=4: req 0x00,0x04,0x08 back-to-back, out_ready=1 → out_addr 0x00 at cycle 2, then one entry per cycle; out_instr matches ROM model.
- out_ready=0, continuous req_valid → exactly 4 accepted (occupancy=4), then req_ready=0; release out_ready → 4 entries drained in order, no loss or duplication.
- Flush with 2 queued and 1 in flight → next cycle out_valid=0, occupancy=0; the killed slot's ROM word never appears; new req 0x100 emerges 2 cycles later.
- clk_en toggling 1-0-1 during a fetch → output delayed by exactly the disabled cycles; data intact.
- ROM_LAT=3, DEPTH=4: full-rate stream → 1 word/cycle after a 4-cycle fill; req_ready never drops with out_ready=1.
- rst asserted with full FIFO and clk_en=0 → all outputs at reset values after one edge.
